// File: rtl/wavepipe_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : wavepipe_uart_rx
// Description : UART 8N1 receiver. Synchronises the serial pin, oversamples it
//               on a divided tick and delivers bytes on a valid/ready holding
//               register. Framing errors and overruns are 1-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module wavepipe_uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_rxd,
  output logic [7:0] io_data,
  output logic       io_valid,
  input  logic       io_ready,
  output logic       io_frameErr,
  output logic       io_overrun,
  output logic       io_busy
);

  // Rounded clock divider producing one tick per oversample slot.
  localparam int c_DIV = (CLK_FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int c_TW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_SW  = $clog2(OVERSAMPLE);

  localparam logic [c_TW-1:0] c_TMAX  = c_TW'(c_DIV - 1);
  localparam logic [c_SW-1:0] c_SHALF = c_SW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_SW-1:0] c_SFULL = c_SW'(OVERSAMPLE - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_DATA  = 3'd2;
  localparam logic [2:0] c_STOP  = 3'd3;
  localparam logic [2:0] c_BREAK = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [c_TW-1:0]        tcnt_q, tcnt_d;
  logic [c_SW-1:0]        scnt_q, scnt_d;
  logic [2:0]             bcnt_q, bcnt_d;
  logic [2:0]             state_q, state_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   dlv_q, dlv_d;
  logic                   w_rxs;
  logic                   w_tick;

  // Synchroniser shift and oversample tick decode.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], io_rxd};
    w_rxs  = sync_q[SYNC_STAGES-1];
    w_tick = (tcnt_q == c_TMAX);
  end

  // Receive FSM, shift register and holding-register handshake.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    dlv_d   = 1'b0;
    tcnt_d  = w_tick ? '0 : tcnt_q + 1'b1;

    case (state_q)
      c_IDLE: begin
        if (!w_rxs) begin
          // Restart the tick phase so sampling aligns with the falling edge.
          state_d = c_START;
          scnt_d  = '0;
          tcnt_d  = '0;
        end
      end
      c_START: begin
        if (w_tick) begin
          if (scnt_q == c_SHALF) begin
            if (w_rxs) begin
              state_d = c_IDLE;   // line back high at mid-bit: glitch
            end else begin
              state_d = c_DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      c_DATA: begin
        if (w_tick) begin
          if (scnt_q == c_SFULL) begin
            shreg_d = {w_rxs, shreg_q[7:1]};
            scnt_d  = '0;
            if (bcnt_q == 3'd7) begin
              state_d = c_STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      c_STOP: begin
        if (w_tick) begin
          if (scnt_q == c_SFULL) begin
            // Leave at mid stop bit so the next start edge is not missed.
            if (w_rxs) begin
              dlv_d   = 1'b1;
              state_d = c_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = c_BREAK;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      c_BREAK: begin
        if (w_rxs) begin
          state_d = c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase

    // A byte may replace the held one only if it is being consumed right now.
    if (dlv_q) begin
      if (!valid_q || io_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && io_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '1;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      state_q <= c_IDLE;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dlv_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      dlv_q   <= dlv_d;
    end
  end

  assign io_data     = data_q;
  assign io_valid    = valid_q;
  assign io_frameErr = ferr_q;
  assign io_overrun  = ovr_q;
  assign io_busy     = (state_q != c_IDLE);

endmodule
`default_nettype wire
